// File: rtl/transport_pkg.sv
// Shared definitions for the transport layer: framing constants, command
// codes and the receive deframer state encoding.
package transport_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h7E;
    localparam int         MAX_WORDS = 64;

    localparam logic [1:0] CMD_DIAL  = 2'b01;
    localparam logic [1:0] CMD_VOICE = 2'b10;

    typedef enum logic [2:0] {
        HUNT,
        TYPE,
        PHONE,
        LEN,
        DATA_HI,
        DATA_LO,
        CHECK,
        SKIP
    } rx_state_e;

endpackage

// File: rtl/transport_rx_commit_buffer.sv
// Sample buffer with a speculative write pointer. Words written for the packet
// in flight stay invisible to the reader until commit; rollback discards them.
module rx_commit_buffer #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [15:0]           wr_data_i,
    input  logic                  commit_i,
    input  logic                  rollback_i,
    input  logic                  rd_en_i,
    output logic [15:0]           rd_data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   free_o
);

    localparam int               DEPTH   = 1 << DEPTH_LOG2;
    localparam int               PW      = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]    DEPTH_V = PW'(DEPTH);

    logic [15:0]   mem [0:DEPTH-1];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   rd_data_q;
    logic          pop;

    // Only committed words can be popped; a read on an empty buffer is dropped.
    assign pop = rd_en_i && (commit_ptr_q != rd_ptr_q);

    // Pointer next-state: rollback wins over write, commit snapshots the write pointer.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (rollback_i) begin
            wr_ptr_d = commit_ptr_q;
        end else if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (commit_i) begin
            commit_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rd_data_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            if (pop) begin
                rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
            end
        end
    end

    // Storage array; write address is always outside the committed region.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = commit_ptr_q - rd_ptr_q;
    assign empty_o   = (commit_ptr_q == rd_ptr_q);
    assign free_o    = DEPTH_V - (wr_ptr_q - rd_ptr_q);

endmodule

// File: rtl/transport_rx_deframer.sv
// Receive deframer: hunts for sync, parses the header, reassembles big-endian
// samples into the commit buffer and publishes them only on a good checksum.
module transport_rx_deframer #(
    parameter int         DEPTH_LOG2 = 9,
    parameter int         MAX_WORDS  = transport_pkg::MAX_WORDS,
    parameter logic [7:0] SYNC_BYTE  = transport_pkg::SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byteIn,
    input  logic                  byteInValid,
    input  logic                  sampleRd,
    output logic [15:0]           sampleOut,
    output logic [DEPTH_LOG2:0]   sampleCount,
    output logic                  sampleEmpty,
    output logic [1:0]            cmdOut,
    output logic [7:0]            phoneNum,
    output logic                  pktDone,
    output logic                  pktError,
    output logic                  busy
);

    import transport_pkg::*;

    localparam int            PW     = DEPTH_LOG2 + 1;
    localparam logic [7:0]    MAX_W8 = 8'(MAX_WORDS);

    rx_state_e     state_q, state_d;
    logic [1:0]    cmd_sh_q, cmd_sh_d;
    logic [7:0]    phone_sh_q, phone_sh_d;
    logic [7:0]    xor_q, xor_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    words_q, words_d;
    logic [7:0]    skip_q, skip_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [7:0]    phone_q, phone_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          wr_en;
    logic          commit;
    logic          rollback;
    logic [PW-1:0] free_words;

    // Packet parser: every transition is qualified by byteInValid so idle gaps are harmless.
    always_comb begin
        state_d    = state_q;
        cmd_sh_d   = cmd_sh_q;
        phone_sh_d = phone_sh_q;
        xor_d      = xor_q;
        hi_d       = hi_q;
        words_d    = words_q;
        skip_d     = skip_q;
        cmd_d      = cmd_q;
        phone_d    = phone_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        if (byteInValid) begin
            unique case (state_q)
                HUNT: begin
                    if (byteIn == SYNC_BYTE) begin
                        state_d = TYPE;
                    end
                end
                TYPE: begin
                    cmd_sh_d = byteIn[1:0];
                    xor_d    = byteIn;
                    state_d  = PHONE;
                end
                PHONE: begin
                    phone_sh_d = byteIn;
                    xor_d      = xor_q ^ byteIn;
                    state_d    = LEN;
                end
                LEN: begin
                    xor_d   = xor_q ^ byteIn;
                    words_d = byteIn;
                    if (byteIn == 8'd0 || byteIn > MAX_W8) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else if (free_words < PW'(byteIn)) begin
                        // Not enough room: swallow payload and checksum to stay aligned.
                        skip_d  = {byteIn[6:0], 1'b1};
                        state_d = SKIP;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
                DATA_HI: begin
                    hi_d    = byteIn;
                    xor_d   = xor_q ^ byteIn;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    wr_en   = 1'b1;
                    xor_d   = xor_q ^ byteIn;
                    words_d = words_q - 8'd1;
                    state_d = (words_q == 8'd1) ? CHECK : DATA_HI;
                end
                CHECK: begin
                    if (byteIn == xor_q) begin
                        commit  = 1'b1;
                        cmd_d   = cmd_sh_q;
                        phone_d = phone_sh_q;
                        done_d  = 1'b1;
                    end else begin
                        rollback = 1'b1;
                        err_d    = 1'b1;
                    end
                    state_d = HUNT;
                end
                SKIP: begin
                    skip_d = skip_q - 8'd1;
                    if (skip_q == 8'd1) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Parser state, shadows and published header fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            cmd_sh_q   <= '0;
            phone_sh_q <= '0;
            xor_q      <= '0;
            hi_q       <= '0;
            words_q    <= '0;
            skip_q     <= '0;
            cmd_q      <= '0;
            phone_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_sh_q   <= cmd_sh_d;
            phone_sh_q <= phone_sh_d;
            xor_q      <= xor_d;
            hi_q       <= hi_d;
            words_q    <= words_d;
            skip_q     <= skip_d;
            cmd_q      <= cmd_d;
            phone_q    <= phone_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    rx_commit_buffer #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_buf (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en_i    (wr_en),
        .wr_data_i  ({hi_q, byteIn}),
        .commit_i   (commit),
        .rollback_i (rollback),
        .rd_en_i    (sampleRd),
        .rd_data_o  (sampleOut),
        .count_o    (sampleCount),
        .empty_o    (sampleEmpty),
        .free_o     (free_words)
    );

    assign cmdOut   = cmd_q;
    assign phoneNum = phone_q;
    assign pktDone  = done_q;
    assign pktError = err_q;
    assign busy     = (state_q != HUNT);

endmodule

// File: tb/tb_transport_rx_deframer.sv
// Directed bench for the receive deframer; expected values are hand computed
// except for bulk fill packets, whose checksum is formed by the bench.
module tb_transport_rx_deframer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byteIn = 8'h00;
    logic        byteInValid = 1'b0;
    logic        sampleRd = 1'b0;
    logic [15:0] sampleOut;
    logic [9:0]  sampleCount;
    logic        sampleEmpty;
    logic [1:0]  cmdOut;
    logic [7:0]  phoneNum;
    logic        pktDone;
    logic        pktError;
    logic        busy;

    int tests = 0;
    int failures = 0;
    int done_pulses = 0;
    int err_pulses = 0;
    int d0;
    int e0;

    always #5 clk = ~clk;

    transport_rx_deframer dut (
        .clk         (clk),
        .reset       (reset),
        .byteIn      (byteIn),
        .byteInValid (byteInValid),
        .sampleRd    (sampleRd),
        .sampleOut   (sampleOut),
        .sampleCount (sampleCount),
        .sampleEmpty (sampleEmpty),
        .cmdOut      (cmdOut),
        .phoneNum    (phoneNum),
        .pktDone     (pktDone),
        .pktError    (pktError),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (pktDone === 1'b1) done_pulses++;
        if (pktError === 1'b1) err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byteIn = b;
        byteInValid = 1'b1;
        tick();
        byteInValid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        repeat ($urandom_range(0, 3)) tick();
        send_byte(b);
    endtask

    task automatic pop();
        sampleRd = 1'b1;
        tick();
        sampleRd = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s [], input bit gaps);
        foreach (s[i]) begin
            if (gaps) send_gap(s[i]);
            else      send_byte(s[i]);
        end
    endtask

    task automatic send_pkt(input logic [7:0] typ, input logic [7:0] ph,
                            input int n, input logic [15:0] base);
        logic [7:0]  x;
        logic [15:0] w;
        send_byte(8'h7E);
        send_byte(typ);
        send_byte(ph);
        send_byte(8'(n));
        x = typ ^ ph ^ 8'(n);
        for (int i = 0; i < n; i++) begin
            w = base + 16'(i);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
        send_byte(x);
    endtask

    logic [7:0] good_pkt [] = '{8'h7E, 8'h01, 8'h2A, 8'h02, 8'hA3, 8'hF1, 8'h12, 8'h34, 8'h5D};
    logic [7:0] bad_pkt  [] = '{8'h7E, 8'h02, 8'h33, 8'h02, 8'hA3, 8'hF1, 8'h12, 8'h34, 8'h48};
    logic [7:0] bad5c    [] = '{8'h7E, 8'h01, 8'h2A, 8'h02, 8'hA3, 8'hF1, 8'h12, 8'h34, 8'h5C};
    logic [7:0] garbage  [] = '{8'h00, 8'hFF, 8'h7F};
    logic [7:0] len0     [] = '{8'h7E, 8'h01, 8'h2A, 8'h00};
    logic [7:0] len65    [] = '{8'h7E, 8'h01, 8'h2A, 8'h41};
    logic [7:0] ovl_head [] = '{8'h7E, 8'h01, 8'h11, 8'h01, 8'hBE};
    logic [7:0] partial  [] = '{8'h7E, 8'h01, 8'h11, 8'h02, 8'hAB};

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_count", 32'(sampleCount), 32'd0);
        chk("rst_empty", 32'(sampleEmpty), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sampleOut", 32'(sampleOut), 32'h0);
        chk("rst_cmd", 32'(cmdOut), 32'd0);
        chk("rst_phone", 32'(phoneNum), 32'h0);
        chk("rst_done", 32'(pktDone), 32'd0);
        chk("rst_err", 32'(pktError), 32'd0);
        reset = 1'b1;
        tick();

        // Good packet
        d0 = done_pulses;
        send_byte(8'h7E);
        chk("busy_after_sync", 32'(busy), 32'd1);
        for (int i = 1; i < 8; i++) send_byte(good_pkt[i]);
        chk("good_no_early_done", 32'(pktDone), 32'd0);
        chk("good_count_pre", 32'(sampleCount), 32'd0);
        send_byte(good_pkt[8]);
        chk("good_done", 32'(pktDone), 32'd1);
        chk("good_err", 32'(pktError), 32'd0);
        chk("good_cmd", 32'(cmdOut), 32'h1);
        chk("good_phone", 32'(phoneNum), 32'h2A);
        chk("good_count", 32'(sampleCount), 32'd2);
        chk("good_busy", 32'(busy), 32'd0);
        tick();
        chk("good_done_fall", 32'(pktDone), 32'd0);
        chk("good_one_pulse", 32'(done_pulses - d0), 32'd1);
        pop();
        chk("good_rd0", 32'(sampleOut), 32'hA3F1);
        chk("good_cnt1", 32'(sampleCount), 32'd1);
        pop();
        chk("good_rd1", 32'(sampleOut), 32'h1234);
        chk("good_empty", 32'(sampleEmpty), 32'd1);
        pop();
        chk("empty_rd_holds", 32'(sampleOut), 32'h1234);
        chk("empty_rd_count", 32'(sampleCount), 32'd0);

        // Bad checksums are rolled back and leave header fields alone
        send_seq(bad_pkt, 1'b0);
        chk("bad_err", 32'(pktError), 32'd1);
        chk("bad_done", 32'(pktDone), 32'd0);
        chk("bad_count", 32'(sampleCount), 32'd0);
        chk("bad_cmd_kept", 32'(cmdOut), 32'h1);
        chk("bad_phone_kept", 32'(phoneNum), 32'h2A);
        send_seq(bad5c, 1'b0);
        chk("bad5c_err", 32'(pktError), 32'd1);
        chk("bad5c_count", 32'(sampleCount), 32'd0);

        // Garbage ahead of a good packet, with idle gaps
        send_seq(garbage, 1'b1);
        chk("garbage_busy", 32'(busy), 32'd0);
        send_seq(good_pkt, 1'b1);
        chk("gap_done", 32'(pktDone), 32'd1);
        chk("gap_count", 32'(sampleCount), 32'd2);
        chk("gap_cmd", 32'(cmdOut), 32'h1);
        chk("gap_phone", 32'(phoneNum), 32'h2A);
        pop();
        chk("gap_rd0", 32'(sampleOut), 32'hA3F1);
        pop();
        chk("gap_rd1", 32'(sampleOut), 32'h1234);
        chk("gap_empty", 32'(sampleEmpty), 32'd1);

        // Illegal lengths
        send_seq(len0, 1'b0);
        chk("len0_err", 32'(pktError), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        send_seq(len65, 1'b0);
        chk("len65_err", 32'(pktError), 32'd1);
        chk("len65_busy", 32'(busy), 32'd0);
        send_pkt(8'h02, 8'h77, 1, 16'hCAFE);
        chk("after_len_done", 32'(pktDone), 32'd1);
        chk("after_len_cmd", 32'(cmdOut), 32'h2);
        chk("after_len_phone", 32'(phoneNum), 32'h77);
        pop();
        chk("after_len_rd", 32'(sampleOut), 32'hCAFE);

        // Fill to 510, overflow packet is skipped
        for (int p = 0; p < 8; p++) begin
            send_pkt(8'h01, 8'(p), (p < 7) ? 64 : 62, 16'h1000 + 16'(p * 64));
        end
        chk("fill_count", 32'(sampleCount), 32'd510);
        e0 = err_pulses;
        send_pkt(8'h01, 8'h99, 4, 16'h5000);
        chk("skip_err", 32'(pktError), 32'd1);
        chk("skip_done", 32'(pktDone), 32'd0);
        chk("skip_count", 32'(sampleCount), 32'd510);
        chk("skip_phone_kept", 32'(phoneNum), 32'h07);
        chk("skip_busy", 32'(busy), 32'd0);
        tick();
        chk("skip_one_pulse", 32'(err_pulses - e0), 32'd1);
        pop();
        chk("fill_rd0", 32'(sampleOut), 32'h1000);
        pop();
        chk("fill_rd1", 32'(sampleOut), 32'h1001);
        chk("fill_count_508", 32'(sampleCount), 32'd508);
        send_pkt(8'h01, 8'h99, 4, 16'h5000);
        chk("full_done", 32'(pktDone), 32'd1);
        chk("full_count", 32'(sampleCount), 32'd512);
        chk("full_empty", 32'(sampleEmpty), 32'd0);
        chk("full_phone", 32'(phoneNum), 32'h99);

        // Reset clears committed data
        reset = 1'b0;
        #1;
        chk("rst2_count", 32'(sampleCount), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Commit and pop in the same cycle
        send_pkt(8'h02, 8'h55, 4, 16'h2000);
        pop();
        chk("ovl_rd0", 32'(sampleOut), 32'h2000);
        chk("ovl_count_pre", 32'(sampleCount), 32'd3);
        send_seq(ovl_head, 1'b0);
        send_byte(8'hEF);
        byteIn = 8'h40;
        byteInValid = 1'b1;
        sampleRd = 1'b1;
        tick();
        byteInValid = 1'b0;
        sampleRd = 1'b0;
        chk("ovl_done", 32'(pktDone), 32'd1);
        chk("ovl_count", 32'(sampleCount), 32'd3);
        chk("ovl_rd1", 32'(sampleOut), 32'h2001);

        // Asynchronous reset mid-DATA_LO
        send_seq(partial, 1'b0);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_count", 32'(sampleCount), 32'd0);
        chk("mid_rst_empty", 32'(sampleEmpty), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out", 32'(sampleOut), 32'h0);
        chk("mid_rst_cmd", 32'(cmdOut), 32'd0);
        chk("mid_rst_phone", 32'(phoneNum), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        send_seq(good_pkt, 1'b0);
        chk("post_rst_done", 32'(pktDone), 32'd1);
        chk("post_rst_count", 32'(sampleCount), 32'd2);
        pop();
        chk("post_rst_rd", 32'(sampleOut), 32'hA3F1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/transport_rx_deframer.md
Name: transport_rx_deframer

Overview:
- Receive-side counterpart of the combined transport stage. Consumes the byte stream that the transmit side produces.
- Hunts for sync, parses the header (command, phone number, word length) and reassembles big-endian 16-bit samples into an output buffer.
- Samples become visible to the session layer only after the packet's XOR checksum passes. A bad or oversize packet is rolled back and never becomes visible.

Parameters:
- DEPTH_LOG2, 9, log2 of sample buffer depth in 16-bit words (512).
- MAX_WORDS, 64, largest legal payload length in words.
- SYNC_BYTE, 8'h7E, packet start marker.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- byteIn  in  8  incoming packet byte.
- byteInValid  in  1  byteIn is consumed on every cycle this is high; no backpressure.
- sampleRd  in  1  pop one committed sample.
- sampleOut  out  16  sample data, registered.
- sampleCount  out  DEPTH_LOG2+1  number of committed, unread words.
- sampleEmpty  out  1  sampleCount==0.
- cmdOut  out  2  command field of the last good packet.
- phoneNum  out  8  phone-number field of the last good packet.
- pktDone  out  1  one-cycle pulse when a good packet commits.
- pktError  out  1  one-cycle pulse when a packet is discarded.
- busy  out  1  high whenever the FSM is not in HUNT.

Behaviour:
- Packet format, in byte order:
  - SYNC_BYTE
  - TYPE: bits[1:0] = cmd, bits[7:2] ignored
  - PHONE
  - LEN: number of words N
  - 2N payload bytes, each word MSB first
  - CHK = XOR of TYPE through the last payload byte
- Reset (reset=0, async):
  - FSM to HUNT.
  - Write, commit and read pointers = 0.
  - sampleOut=0, cmdOut=0, phoneNum=0, pktDone=0, pktError=0, busy=0, sampleEmpty=1, sampleCount=0.
  - Reset mid-packet discards everything, including committed words.
- FSM advances only on cycles with byteInValid=1.
  - HUNT: byte==SYNC_BYTE -> TYPE; any other byte is dropped.
  - TYPE: latch shadow cmd; running XOR = byte -> PHONE.
  - PHONE: latch shadow phone; XOR -> LEN.
  - LEN: XOR, then:
    - N==0 or N>MAX_WORDS: pktError, go to HUNT.
    - Free space (depth - (wrPtr - rdPtr)) < N: go to SKIP with 2N+1 bytes remaining.
    - Otherwise go to DATA_HI.
  - DATA_HI: hold byte as high half -> DATA_LO.
  - DATA_LO: write {hi,byte} at wrPtr; wrPtr+1; decrement word counter. Counter reaches 0 -> CHECK, else -> DATA_HI.
  - CHECK, byte==XOR:
    - commitPtr <= wrPtr.
    - cmdOut/phoneNum <= shadows.
    - pktDone pulse.
    - go to HUNT.
  - CHECK, mismatch: wrPtr <= commitPtr (rollback), pktError pulse, go to HUNT.
  - SKIP: count down remaining bytes; on the last byte pktError, go to HUNT. The stream stays aligned.
- A SYNC_BYTE value arriving mid-packet is treated as data; there is no resync.
- Read side:
  - sampleRd with commitPtr!=rdPtr pops: sampleOut <= mem[rdPtr] on the next edge; rdPtr+1.
  - sampleRd while empty is ignored; sampleOut holds.
- Pointers are DEPTH_LOG2+1 bits and wrap naturally.
  - sampleCount = commitPtr - rdPtr.
  - Uncommitted words are invisible to the read side.
- Simultaneous commit and pop in the same cycle: both take effect; sampleCount = old + N - 1.
- Pulse latency: pktDone/pktError assert the cycle after the CHK/final byte edge (registered). sampleCount updates on that same cycle.
- Idle cycles (byteInValid=0) mid-packet are permitted, with unlimited gaps.

Decomposition:
- Shared package transport_pkg:
  - SYNC_BYTE and MAX_WORDS constants.
  - FSM state enum: HUNT, TYPE, PHONE, LEN, DATA_HI, DATA_LO, CHECK, SKIP.
  - Command codes 2'b01 = dial, 2'b10 = voice data.
- Sub-module rx_commit_buffer:
  - Dual-pointer RAM with speculative write pointer, commit and rollback strobes, registered read.
  - Exposes count and empty.

Test Plan:
- Good packet 7E,01,2A,02,A3,F1,12,34,5D -> pktDone one pulse; cmdOut=01, phoneNum=2A, sampleCount=2; two reads give A3F1 then 1234; sampleEmpty=1 afterwards.
- Same packet with CHK=5C -> pktError pulse; sampleCount stays 0; cmdOut/phoneNum keep their prior values; next good packet commits correctly.
- Garbage 00,FF,7F ahead of a good packet, plus random byteInValid gaps -> garbage ignored; same results as the good-packet case.
- LEN=0 and LEN=65 -> pktError right after the LEN byte; busy returns to 0; following packet parses.
- Fill buffer to 510 committed words, then send a 4-word packet -> SKIP consumes all 9 remaining bytes, pktError, count stays 510. Pop 2, resend -> commits, count=512.
- Assert reset low mid-DATA_LO with 3 committed words -> all outputs at reset values immediately; count=0, FSM in HUNT.
